// File: rtl/ntt_intt_cu_param.sv
// ntt_intt_cu_param
// Control unit for the NTT/INTT accelerator. It sits between the bus register
// file and the NTT datapath / coefficient RAM, and it runs three phases:
//   LOAD    - accepts N_COEFF coefficient beats and writes them to RAM
//   COMPUTE - starts the datapath and waits for completion, with a timeout
//   STORE   - reads N_COEFF coefficients out to a sink that can stall
// When a COMPUTE or STORE phase finishes, the unit raises an interrupt. The
// interrupt stays high until the host acknowledges it.
//
// Ports
//   clk_i, rst_i                   clock; synchronous active-high reset
//   cmd_load_i/start_i/store_i     command levels, sampled in IDLE, or in DONE with irq_ack_i
//   operation_i                    op code latched when a command is accepted
//   abort_i                        returns LOAD/COMPUTE/STORE to IDLE
//   load_valid_i / load_ready_o    coefficient input handshake
//   load_we_o, load_addr_o         coefficient RAM write strobe and address
//   store_ready_i / store_valid_o  coefficient output handshake
//   store_addr_o                   coefficient RAM read address
//   done_dp_i, start_dp_o          datapath completion pulse / start pulse
//   op_o                           latched operation
//   busy_o, status_done_o, status_err_o, intr_o, irq_ack_i  status and interrupt
module ntt_intt_cu_param #(
  parameter int N_COEFF     = 256,
  parameter int NTT_CYCLES  = 907,
  parameter int INTT_CYCLES = 907,
  parameter int CNT_W       = 11,
  parameter int ADDR_W      = $clog2(N_COEFF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_load_i,
  input  logic              cmd_start_i,
  input  logic              cmd_store_i,
  input  logic [5:0]        operation_i,
  input  logic              abort_i,
  input  logic              load_valid_i,
  input  logic              store_ready_i,
  input  logic              done_dp_i,
  input  logic              irq_ack_i,
  output logic              start_dp_o,
  output logic [5:0]        op_o,
  output logic              load_ready_o,
  output logic              load_we_o,
  output logic [ADDR_W-1:0] load_addr_o,
  output logic              store_valid_o,
  output logic [ADDR_W-1:0] store_addr_o,
  output logic              busy_o,
  output logic              status_done_o,
  output logic              status_err_o,
  output logic              intr_o
);

  localparam logic [5:0] OP_NULL = 6'd0;
  localparam logic [5:0] OP_NTT  = 6'd1;
  localparam logic [5:0] OP_INTT = 6'd2;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_COEFF - 1);
  localparam logic [CNT_W-1:0] NTT_LAST  = CNT_W'(NTT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INTT_LAST = CNT_W'(INTT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_STORE,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       op_reg, op_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  // Only NTT and INTT drive the datapath. NULL and illegal codes skip it.
  logic             op_is_xform;
  logic [CNT_W-1:0] lat_last;

  assign op_is_xform = (op_reg == OP_NTT) || (op_reg == OP_INTT);
  assign lat_last    = (op_reg == OP_INTT) ? INTT_LAST : NTT_LAST;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_NULL;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    done_next  = done_reg;
    err_next   = err_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // DONE holds until acknowledged. The acknowledge cycle can also accept a command.
        if (state_reg == ST_IDLE || irq_ack_i) begin
          state_next = ST_IDLE;
          if (cmd_load_i || cmd_start_i || cmd_store_i) begin
            op_next   = operation_i;
            done_next = 1'b0;
            err_next  = 1'b0;
            cnt_next  = '0;
            if (cmd_load_i)       state_next = ST_LOAD;
            else if (cmd_start_i) state_next = ST_COMPUTE;
            else                  state_next = ST_STORE;
          end
        end
      end

      ST_LOAD: begin
        if (abort_i || !op_is_xform) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (load_valid_i) begin
          if (cnt_reg == LAST_BEAT) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      ST_COMPUTE: begin
        if (abort_i) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (op_reg == OP_NULL) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else if (!op_is_xform) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end else if (done_dp_i) begin
          // If completion arrives on the timeout cycle, this branch wins, so it counts as success.
          state_next = ST_DONE;
          done_next  = 1'b1;
          cnt_next   = '0;
        end else if (cnt_reg == lat_last) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_STORE: begin
        if (abort_i) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (store_ready_i) begin
          if (cnt_reg == LAST_BEAT) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The counter reads zero only on the first COMPUTE cycle, so start is a single pulse.
  assign start_dp_o    = (state_reg == ST_COMPUTE) && (cnt_reg == '0) && op_is_xform;
  assign op_o          = op_reg;
  assign load_ready_o  = (state_reg == ST_LOAD) && op_is_xform;
  assign load_we_o     = load_valid_i && load_ready_o;
  assign load_addr_o   = cnt_reg[ADDR_W-1:0];
  assign store_valid_o = (state_reg == ST_STORE);
  assign store_addr_o  = cnt_reg[ADDR_W-1:0];
  assign busy_o        = (state_reg == ST_LOAD) || (state_reg == ST_COMPUTE) ||
                         (state_reg == ST_STORE);
  assign status_done_o = done_reg;
  assign status_err_o  = err_reg;
  assign intr_o        = (state_reg == ST_DONE);

endmodule
